serial_adder_ctrl: RTL and testbench

- Bit-serial add/subtract engine built around one shared `full_adder` instance (ports x, y, cin, sum, cout).
- An FSM sequences WIDTH operand bits through the adder, LSB first, one bit per clock, and holds the carry in a flop between bits.
- Valid/ready handshakes on input and output let a little_proc ALU or microsequencer issue operations without a WIDTH-bit ripple adder.

---
 rtl/serial_adder_ctrl.sv | 131 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: a single full adder processes one operand bit
// per clock, LSB first, with valid/ready handshakes on request and result.

module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));
endmodule

module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_overflow;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_sum;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

  full_adder u_fa (
    .x    (r_a_sh[0]),
    .y    (r_b_sh[0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign w_res_next = {w_sum, r_res_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_res_sh    <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            // Subtraction as a + ~b + 1: invert b and seed the carry with 1.
            r_a_sh     <= a;
            r_b_sh     <= sub ? ~b : b;
            r_carry    <= sub;
            r_cnt      <= '0;
            r_state    <= S_RUN;
            r_in_ready <= 1'b0;
          end
        end
        S_RUN: begin
          r_res_sh <= w_res_next;
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_carry  <= w_cout;
          if (r_cnt == LAST_BIT) begin
            r_cnt       <= '0;
            r_result    <= w_res_next;
            r_carry_out <= w_cout;
            r_overflow  <= r_carry ^ w_cout;
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: 8-bit instance with hand-computed
// vectors plus an exhaustive 2-bit instance against an arithmetic model.

module tb_serial_adder_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
  logic [7:0] a, b, result;

  logic       in_valid2, in_ready2, sub2, out_valid2, out_ready2, carry_out2, overflow2;
  logic [1:0] a2, b2, result2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .carry_out(carry_out2), .overflow(overflow2)
  );

  // Stimulus-only helpers; every comparison lives in the test tasks.
  task automatic start8(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic consume8();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'h01; sub = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0; out_ready2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_no_accept got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    int cyc;
    start8(8'h3C, 8'h5A, 1'b0);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL add_run_flags got=%b%b exp=00", out_valid, in_ready); end
    wait_done8(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL add_latency got=%0d exp=8", cyc); end
    checks++; if (result !== 8'h96) begin errors++; $display("FAIL add_result got=%h exp=96", result); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL add_carry got=%b exp=0", carry_out); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL add_overflow got=%b exp=1", overflow); end
    consume8();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL add_consume got=%b%b exp=10", in_ready, out_valid); end
  endtask

  task automatic test_add_wrap();
    int cyc;
    start8(8'hFF, 8'h01, 1'b0);
    wait_done8(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL wrap_latency got=%0d exp=8", cyc); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL wrap_result got=%h exp=00", result); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL wrap_carry got=%b exp=1", carry_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_overflow got=%b exp=0", overflow); end
    consume8();
  endtask

  task automatic test_sub();
    int cyc;
    start8(8'h05, 8'h07, 1'b1);
    wait_done8(cyc);
    checks++; if (result !== 8'hFE) begin errors++; $display("FAIL sub1_result got=%h exp=fe", result); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL sub1_carry got=%b exp=0", carry_out); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sub1_overflow got=%b exp=0", overflow); end
    consume8();
    start8(8'h80, 8'h01, 1'b1);
    wait_done8(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL sub2_latency got=%0d exp=8", cyc); end
    checks++; if (result !== 8'h7F) begin errors++; $display("FAIL sub2_result got=%h exp=7f", result); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL sub2_carry got=%b exp=1", carry_out); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sub2_overflow got=%b exp=1", overflow); end
    consume8();
  endtask

  task automatic test_backpressure();
    int cyc;
    start8(8'h10, 8'h20, 1'b0);
    wait_done8(cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 8'hAA; b = 8'h55;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_flags cyc=%0d got=%b%b exp=10", i, out_valid, in_ready); end
      checks++; if (result !== 8'h30) begin errors++; $display("FAIL bp_result cyc=%0d got=%h exp=30", i, result); end
    end
    // Release while a request is also asserted: it must not be taken from DONE.
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b%b exp=10", in_ready, out_valid); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept got=%b exp=1", in_ready); end
    start8(8'h01, 8'h01, 1'b0);
    wait_done8(cyc);
    checks++; if (result !== 8'h02 || carry_out !== 1'b0) begin errors++; $display("FAIL bp_fresh got=%h/%b exp=02/0", result, carry_out); end
    consume8();
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    start8(8'hFF, 8'hFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_flags got=%b%b exp=10", in_ready, out_valid); end
    checks++; if (result !== 8'h00 || carry_out !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst_outputs got=%h/%b/%b exp=00/0/0", result, carry_out, overflow); end
    start8(8'h01, 8'h00, 1'b0);
    wait_done8(cyc);
    checks++; if (cyc != 8) begin errors++; $display("FAIL midrst_latency got=%0d exp=8", cyc); end
    checks++; if (result !== 8'h01 || carry_out !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst_next got=%h/%b/%b exp=01/0/0", result, carry_out, overflow); end
    consume8();
  endtask

  task automatic test_exhaustive_w2();
    logic [1:0] bb, er;
    logic [2:0] s;
    logic       ec, ev;
    int         n;
    for (int op = 0; op < 32; op++) begin
      a2 = 2'(op >> 3); b2 = 2'(op >> 1); sub2 = op[0];
      bb = sub2 ? ~b2 : b2;
      s  = 3'(a2) + 3'(bb) + 3'(sub2);
      er = s[1:0]; ec = s[2];
      ev = (a2[1] == bb[1]) && (er[1] != a2[1]);
      n = 0;
      while (!in_ready2 && n < 20) begin @(posedge clk); #1; n++; end
      in_valid2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      n = 0;
      while (!out_valid2 && n < 20) begin @(posedge clk); #1; n++; end
      checks++; if (n != 2) begin errors++; $display("FAIL w2_latency a=%0d b=%0d sub=%b got=%0d exp=2", a2, b2, sub2, n); end
      checks++;
      if (result2 !== er || carry_out2 !== ec || overflow2 !== ev) begin
        errors++;
        $display("FAIL w2_op a=%0d b=%0d sub=%b got=%0d/%b/%b exp=%0d/%b/%b", a2, b2, sub2, result2, carry_out2, overflow2, er, ec, ev);
      end
      out_ready2 = 1'b1;
      @(posedge clk); #1;
      out_ready2 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_add_wrap();
    test_sub();
    test_backpressure();
    test_reset_mid_run();
    test_exhaustive_w2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
